// File: rtl/serial_word_receiver_if.sv
// Bundle of the serial_word_receiver signals other than clock and reset.
// master: the side that drives serial bits and consumes the received words.
// slave:  the receiver itself.
interface serial_word_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             serial_in;
  logic             bit_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             frame_abort;
  logic             overrun;
  logic             overrun_clr;
  logic             parity_err;

  modport master (
    output serial_in, bit_valid, frame_start, data_ready, overrun_clr,
    input  data_out, data_valid, busy, frame_abort, overrun, parity_err
  );

  modport slave (
    input  serial_in, bit_valid, frame_start, data_ready, overrun_clr,
    output data_out, data_valid, busy, frame_abort, overrun, parity_err
  );
endinterface

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: collects a framed serial bit stream into WIDTH-bit
// words and presents each on a valid/ready output register.
// Optional feature macro PARITY_CHECK_EN: when defined, every word is
// followed by an even-parity bit; mismatching words are discarded and
// reported on parity_err. When undefined, parity_err is tied low.
module serial_word_receiver #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  serial_word_receiver_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECV   = 2'd1;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             abort_n;
  logic             ovr_set;

  logic [WIDTH-1:0] dout_q;
  logic             dvalid_q;
  logic             abort_q;
  logic             overrun_q;
`ifdef PARITY_CHECK_EN
  logic             perr_n;
  logic             perr_q;
`endif

  // Shift candidates: continue the current word, or begin a fresh word
  // from a cleared register so nothing from an earlier frame survives.
  always_comb begin
    shifted = '0;
    first   = '0;
    if (LSB_FIRST) begin
      shifted          = {bus.serial_in, sreg[WIDTH-1:1]};
      first[WIDTH-1]   = bus.serial_in;
    end else begin
      shifted          = {sreg[WIDTH-2:0], bus.serial_in};
      first[0]         = bus.serial_in;
    end
  end

  // Frame FSM: next state, shift register, bit count and event strobes.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    cnt_n     = cnt;
    word      = shifted;
    word_done = 1'b0;
    abort_n   = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_n    = 1'b0;
`endif
    if (bus.bit_valid) begin
      if (bus.frame_start) begin
        // A frame start anywhere but IDLE abandons the partial frame.
        abort_n = (state != IDLE);
        sreg_n  = first;
        cnt_n   = CW'(1);
        state_n = RECV;
      end else begin
        case (state)
          IDLE: begin
            // Stray bits outside a frame are ignored.
          end
          RECV: begin
            sreg_n = shifted;
            if (cnt == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
              cnt_n   = CW'(WIDTH);
              state_n = PARITY;
`else
              word_done = 1'b1;
              cnt_n     = '0;
              state_n   = IDLE;
`endif
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            word = sreg;
            if (bus.serial_in == (^sreg)) begin
              word_done = 1'b1;
            end else begin
              perr_n = 1'b1;
            end
            cnt_n   = '0;
            state_n = IDLE;
          end
`endif
          default: begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        endcase
      end
    end
  end

  // A completed word is dropped only if the held word is neither empty
  // nor being accepted this cycle.
  always_comb begin
    ovr_set = word_done & dvalid_q & ~bus.data_ready;
  end

  // FSM and shift-path registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  // Output register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (word_done && (!dvalid_q || bus.data_ready)) begin
        dout_q   <= word;
        dvalid_q <= 1'b1;
      end else if (dvalid_q && bus.data_ready) begin
        dvalid_q <= 1'b0;
      end
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // Single-cycle event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      abort_q <= abort_n;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_n;
`endif
    end
  end

  assign bus.data_out    = dout_q;
  assign bus.data_valid  = dvalid_q;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_abort = abort_q;
  assign bus.overrun     = overrun_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err  = perr_q;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver: one MSB-first and one
// LSB-first instance receive the same serial stream.
module tb_serial_word_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b0;
  logic bit_valid = 1'b0;
  logic frame_start = 1'b0;
  logic data_ready = 1'b0;
  logic overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int ab0 = 0, ab1 = 0, pe0 = 0, pe1 = 0;
  int ab_base, pe_base;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] e0, e1;

  always #5 clk = ~clk;

  serial_word_receiver_if #(.WIDTH(4)) bus0 ();
  serial_word_receiver_if #(.WIDTH(4)) bus1 ();

  assign bus0.serial_in   = serial_in;
  assign bus0.bit_valid   = bit_valid;
  assign bus0.frame_start = frame_start;
  assign bus0.data_ready  = data_ready;
  assign bus0.overrun_clr = overrun_clr;
  assign bus1.serial_in   = serial_in;
  assign bus1.bit_valid   = bit_valid;
  assign bus1.frame_start = frame_start;
  assign bus1.data_ready  = data_ready;
  assign bus1.overrun_clr = overrun_clr;

  serial_word_receiver #(.WIDTH(4), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0)
  );
  serial_word_receiver #(.WIDTH(4), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  function automatic logic [3:0] rev4(input logic [3:0] w);
    rev4 = {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_bit(input logic d, input logic fs);
    @(posedge clk); #1;
    serial_in = d; bit_valid = 1'b1; frame_start = fs;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic expect_word(input logic [3:0] w);
    q0.push_back(w);
    q1.push_back(rev4(w));
  endtask

  // Sends w first-bit-first (w[3] first) with frame_start on bit 1,
  // plus a correct parity bit when parity checking is built in.
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) begin
      push_bit(w[i], (i == 3));
      if (i < 3) begin
        check("busy_mid0", 32'(bus0.busy), 32'd1);
        check("busy_mid1", 32'(bus1.busy), 32'd1);
      end
    end
`ifdef PARITY_CHECK_EN
    push_bit(^w, 1'b0);
    check("busy_par0", 32'(bus0.busy), 32'd1);
`endif
  endtask

  // Scoreboard monitor: pops one expected word per accepted handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.data_valid && bus0.data_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL word_msb unexpected: got %b, required none", bus0.data_out);
        end else begin
          e0 = q0.pop_front();
          if (bus0.data_out !== e0) begin
            errors++;
            $display("FAIL word_msb: got %b, required %b", bus0.data_out, e0);
          end
        end
      end
      if (bus1.data_valid && bus1.data_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL word_lsb unexpected: got %b, required none", bus1.data_out);
        end else begin
          e1 = q1.pop_front();
          if (bus1.data_out !== e1) begin
            errors++;
            $display("FAIL word_lsb: got %b, required %b", bus1.data_out, e1);
          end
        end
      end
      if (bus0.frame_abort) ab0++;
      if (bus1.frame_abort) ab1++;
      if (bus0.parity_err) pe0++;
      if (bus1.parity_err) pe1++;
    end
  end

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_dout0", 32'(bus0.data_out), 32'd0);
    check("rst_dv0", 32'(bus0.data_valid), 32'd0);
    check("rst_busy0", 32'(bus0.busy), 32'd0);
    check("rst_abort0", 32'(bus0.frame_abort), 32'd0);
    check("rst_ovr0", 32'(bus0.overrun), 32'd0);
    check("rst_perr0", 32'(bus0.parity_err), 32'd0);
    check("rst_dv1", 32'(bus1.data_valid), 32'd0);
    #20 rst = 1'b0;

    // Basic word 1010, one-cycle valid with ready held high
    data_ready = 1'b1;
    expect_word(4'b1010);
    send_word(4'b1010);
    idle_cycle();
    check("t1_dv0", 32'(bus0.data_valid), 32'd1);
    check("t1_dout0", 32'(bus0.data_out), 32'b1010);
    check("t1_dout1", 32'(bus1.data_out), 32'b0101);
    check("t1_busy_end", 32'(bus0.busy), 32'd0);
    idle_cycle();
    check("t1_dv_drop", 32'(bus0.data_valid), 32'd0);

    // Bits without frame_start in IDLE are ignored
    push_bit(1'b1, 1'b0);
    push_bit(1'b1, 1'b0);
    idle_cycle();
    check("stray_busy", 32'(bus0.busy), 32'd0);
    check("stray_dv", 32'(bus0.data_valid), 32'd0);

    // Gaps with bit_valid low hold the partial word
    expect_word(4'b0110);
    push_bit(1'b0, 1'b1);
    push_bit(1'b1, 1'b0);
    idle_cycle();
    idle_cycle();
    check("gap_busy", 32'(bus0.busy), 32'd1);
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
    push_bit(1'b0, 1'b0);
`endif
    idle_cycle();
    check("gap_dout0", 32'(bus0.data_out), 32'b0110);
    idle_cycle();

    // Overrun: second word dropped while the first is held
    data_ready = 1'b0;
    expect_word(4'b1010);
    send_word(4'b1010);
    send_word(4'b0110);
    idle_cycle();
    check("ovr_flag0", 32'(bus0.overrun), 32'd1);
    check("ovr_flag1", 32'(bus1.overrun), 32'd1);
    check("ovr_dout0", 32'(bus0.data_out), 32'b1010);
    check("ovr_dout1", 32'(bus1.data_out), 32'b0101);
    check("ovr_dv0", 32'(bus0.data_valid), 32'd1);
    @(posedge clk); #1;
    data_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_sticky", 32'(bus0.overrun), 32'd1);
    check("ovr_dv_drop", 32'(bus0.data_valid), 32'd0);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    check("ovr_clr0", 32'(bus0.overrun), 32'd0);
    check("ovr_clr1", 32'(bus1.overrun), 32'd0);

    // Abort and restart mid-frame
    ab_base = ab0;
    push_bit(1'b1, 1'b1);
    push_bit(1'b1, 1'b0);
    expect_word(4'b0011);
    send_word(4'b0011);
    idle_cycle();
    idle_cycle();
    check("abort_cnt0", 32'(ab0 - ab_base), 32'd1);
    check("abort_cnt1", 32'(ab1 - ab_base), 32'd1);

    // Reset mid-frame discards the partial word
    push_bit(1'b1, 1'b1);
    push_bit(1'b1, 1'b0);
    @(posedge clk); #1;
    bit_valid = 1'b0; frame_start = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus0.busy), 32'd0);
    check("mid_rst_dv", 32'(bus0.data_valid), 32'd0);
    #10 rst = 1'b0;
    expect_word(4'b1001);
    send_word(4'b1001);
    idle_cycle();
    check("post_rst_dout0", 32'(bus0.data_out), 32'b1001);
    idle_cycle();

`ifdef PARITY_CHECK_EN
    // Correct parity: 1010 with parity 0 is delivered
    expect_word(4'b1010);
    send_word(4'b1010);
    idle_cycle();
    check("par_ok_dv", 32'(bus0.data_valid), 32'd1);
    idle_cycle();
    // Wrong parity: 1011 requires 1, sending 0 discards the word
    pe_base = pe0;
    push_bit(1'b1, 1'b1);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b0);
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    idle_cycle();
    check("par_bad_dv", 32'(bus0.data_valid), 32'd0);
    check("par_bad_perr", 32'(bus0.parity_err), 32'd1);
    idle_cycle();
    check("par_bad_cnt", 32'(pe0 - pe_base), 32'd1);
    check("par_total1", 32'(pe1), 32'd1);
`else
    check("perr_never0", 32'(pe0), 32'd0);
    check("perr_never1", 32'(pe1), 32'd0);
`endif

    // Drain: every expected word must have been seen, bounded wait
    for (int n = 0; n < 20; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receive end of the team's serial shift link. Collects a framed serial bit stream into WIDTH-bit parallel words.
- Presents each word on a valid/ready output register.
- Sits downstream of the universal shift register when that register is used as a parallel-in/serial-out transmitter. Rebuilds the words that the transmitter loaded in parallel.

Parameters:
- WIDTH, 4, data bits per word (>= 2).
- LSB_FIRST, 0, 0: first received bit becomes the MSB (left shift, new bit enters bit 0); 1: first received bit becomes the LSB (right shift, new bit enters bit WIDTH-1).

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in for this cycle.
- frame_start  input  1  marks the sampled bit as first bit of a word; ignored unless bit_valid=1.
- data_out  output  WIDTH  received word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid & data_ready.
- busy  output  1  high while a frame is partially received.
- frame_abort  output  1  one-cycle pulse: frame_start arrived mid-frame.
- overrun  output  1  sticky: a completed word was dropped; cleared by overrun_clr or reset.
- overrun_clr  input  1  clears overrun (set takes priority in the same cycle).
- parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature).

Behaviour:
- Reset (async, immediate): state=IDLE, shift register=0, bit count=0, data_out=0, data_valid=0, busy=0, frame_abort=0, overrun=0, parity_err=0.
- Reset mid-frame discards the partial word and any held output word.
- States:
  - IDLE: waits for bit_valid & frame_start. Loads the bit, count=1, goes to RECV. bit_valid without frame_start is ignored.
  - RECV: each bit_valid shifts serial_in in and increments count.
  - PARITY: exists only with the optional feature.
- Cycles with bit_valid=0 hold all state.
- Word completion: the cycle that samples data bit WIDTH is the completion cycle. Without parity, the word transfers to the output stage and the FSM returns to IDLE.
- Latency: data_out/data_valid update on the clock edge that samples the last bit, so they are visible the following cycle.
- Shift rule:
  - LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - LSB_FIRST=1: sreg <= {serial_in, sreg[WIDTH-1:1]}.
- busy = (state != IDLE).
- bit_valid & frame_start in RECV/PARITY: abort the current frame, pulse frame_abort, restart with this bit as bit 1 (count=1). The output register is untouched.
- Output register:
  - Handshake completes when data_valid & data_ready; data_valid drops next cycle unless a new word loads in the same cycle.
  - Completion while data_valid=1 & data_ready=0: new word dropped, data_out unchanged, overrun set.
  - Completion in the same cycle as an accepted handshake: new word loads, data_valid stays 1, no overrun.
- data_out is stable whenever data_valid=1 and no handshake has occurred.
- Bit counter width is clog2(WIDTH+1). No wrap-around: completion returns the counter to 0.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- With the macro defined:
  - After data bit WIDTH, the FSM enters PARITY and waits for one more bit_valid carrying an even-parity bit (XOR of the data bits).
  - Match: the word transfers to the output stage (overrun rules apply).
  - Mismatch: the word is discarded, parity_err pulses one cycle, data_valid is unaffected.
  - frame_start on the parity bit counts as an abort/restart.
  - Latency is measured from the parity bit.
- Without the macro: no PARITY state; parity_err is tied to 0.

Test Plan:
- Reset, then bits 1,0,1,0 with frame_start on the first bit, LSB_FIRST=0, data_ready=1 -> data_out=4'b1010 and data_valid=1 the cycle after the 4th bit, for 1 cycle; busy high for bits 1-3.
- LSB_FIRST=1, same bits 1,0,1,0 -> data_out=4'b0101.
- data_ready=0: send 1010, then 0110 -> data_out stays 1010, overrun=1. Raise data_ready, then pulse overrun_clr -> data_valid drops, overrun=0.
- Send 1,1, then frame_start with 0,0,1,1 -> frame_abort pulses once, data_out=4'b0011.
- Assert reset after 2 bits, deassert, send 1001 -> data_out=4'b1001, with no leftover bits from the earlier partial frame.
- PARITY_CHECK_EN defined:
  - 1010 + parity 0 -> data_out=1010, data_valid=1.
  - 1011 + parity 0 -> parity_err pulses, data_valid stays 0.
